mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipelined core. Serialises requests under a fixed data-first priority, issues one registered transaction at a time on a request/acknowledge memory port, and returns read data with a one-cycle valid. It supplies the fetch and memory stall conditions to the hazard logic, drops fetch responses killed by a taken branch, and runs a watchdog on unresponsive memory.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- TIMEOUT, 255, max cycles in a busy state before the watchdog fires (≥1)

- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- IReqF  in  1  fetch requests a read; held until IValidF or IKillF
- IAddrF  in  ADDR_WIDTH  fetch address
- IKillF  in  1  pending/offered fetch is squashed (taken branch/jump)
- IRdataF  out  DATA_WIDTH  instruction word
- IValidF  out  1  IRdataF valid, one-cycle pulse
- DReqM  in  1  memory stage requests access; held until DValidM
- DWriteM  in  1  1 = store, 0 = load
- DAddrM  in  ADDR_WIDTH  data address
- DWriteDataM  in  DATA_WIDTH  store data
- DRdataM  out  DATA_WIDTH  load data
- DValidM  out  1  data access complete (loads and stores), one-cycle pulse
- StallF  out  1  IReqF & ~IValidF
- StallM  out  1  DReqM & ~DValidM
- MemReq  out  1  transaction active toward memory
- MemWe  out  1  transaction is a write
- MemAddr  out  ADDR_WIDTH  registered address
- MemWData  out  DATA_WIDTH  registered write data
- MemRData  in  DATA_WIDTH  read data, valid with MemAck
- MemAck  in  1  memory completes the transaction this cycle
- BusErr  out  1  sticky watchdog error flag

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if DReqM → BUSY_D, latch DAddrM/DWriteDataM/DWriteM; else if IReqF & ~IKillF → BUSY_I, latch IAddrF with MemWe=0; else stay.
- Simultaneous DReqM and IReqF: data wins; fetch waits (StallF stays high).
- BUSY_x: MemReq=1; MemAddr/MemWe/MemWData constant for the whole transaction.
- BUSY_I & MemAck: IValidF=1, IRdataF=MemRData, unless kill flag set (IValidF=0); → IDLE.
- BUSY_D & MemAck: DValidM=1, DRdataM=MemRData (don't-care on stores); → IDLE.
- Kill flag: set when IKillF is high in BUSY_I; cleared on entering IDLE. A killed transaction still completes on the memory port; its data is discarded.
- Valids are combinational from MemAck and the state; the pipeline advances on that edge, so a re-presented request the following cycle is a new request.
- Watchdog: counts cycles in BUSY_x; cleared in IDLE. On reaching TIMEOUT without MemAck: BusErr←1 (sticky until reset), MemReq drops, the owning valid pulses with data 0 (fetch: suppressed if killed), → IDLE.
- MemAck in IDLE is ignored.

## Timing
- Reset values: state IDLE, MemReq 0, MemWe 0, MemAddr 0, MemWData 0, IValidF 0, DValidM 0, kill 0, watchdog 0, BusErr 0. IRdataF/DRdataM are 0 whenever their valid is 0.
- Reset mid-transaction: MemReq low the cycle after reset is sampled. The outstanding transaction is abandoned.
- Grant latency: request seen in IDLE at cycle 0 → MemReq high at cycle 1.
- Minimum access: MemAck at cycle 1 → valid at cycle 1; next grant MemReq at cycle 3 (one IDLE cycle between transactions).
- Throughput: at most one transaction per 2 cycles.
- Watchdog: MemReq high for exactly TIMEOUT cycles, then error valid on the last busy cycle.
- StallF/StallM are combinational; there is no registered delay.

## Structure
- Package mem_arb_pkg: state enum {IDLE, BUSY_I, BUSY_D}, default ADDR_WIDTH/DATA_WIDTH constants. Owner encoding is implied by state.
- Sub-module arb_watchdog: TIMEOUT-parameterised counter with clear/enable inputs and an expired output; width $clog2(TIMEOUT+1).
- Top: FSM, transaction registers, kill flag, BusErr, and output muxing.

## Test plan
- Single fetch: IReqF, IAddrF=0x100, MemAck one cycle after MemReq with MemRData=0x00500093 → IValidF at cycle 2 with that word, StallF high cycles 0–1, low at 2.
- Contention: IReqF and DReqM (load 0x2000) together at cycle 0 → data transaction first (MemAddr=0x2000, MemWe=0). Fetch MemReq issues only after DValidM plus one IDLE cycle.
- Store: DReqM, DWriteM=1, DAddrM=0x2004, DWriteDataM=0xDEADBEEF → MemWe=1, MemWData=0xDEADBEEF held until MemAck; DValidM pulses once.
- Kill: IKillF pulsed during BUSY_I with MemAck 3 cycles later → MemReq held to completion, IValidF never asserts, next request is accepted normally.
- Watchdog with TIMEOUT=4 and MemAck tied low → MemReq high for 4 cycles, then BusErr=1 sticky, valid pulses with data 0, FSM back in IDLE.
- Reset asserted during BUSY_D → next cycle MemReq=0, state IDLE, BusErr=0. A held DReqM is re-granted after reset releases.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state type and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter: expires on the TIMEOUT-th consecutive enabled cycle.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear dominates enable
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Data-first arbiter sharing one request/acknowledge memory port between
// instruction fetch and the memory stage, with kill handling and a watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  IReqF,
  input  logic [ADDR_WIDTH-1:0] IAddrF,
  input  logic                  IKillF,
  output logic [DATA_WIDTH-1:0] IRdataF,
  output logic                  IValidF,
  input  logic                  DReqM,
  input  logic                  DWriteM,
  input  logic [ADDR_WIDTH-1:0] DAddrM,
  input  logic [DATA_WIDTH-1:0] DWriteDataM,
  output logic [DATA_WIDTH-1:0] DRdataM,
  output logic                  DValidM,
  output logic                  StallF,
  output logic                  StallM,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData,
  input  logic                  MemAck,
  output logic                  BusErr
);

  arb_state_e            state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  kill_q, kill_d;
  logic                  bus_err_q, bus_err_d;
  logic                  busy;
  logic                  expired;
  logic                  done;
  logic                  timeout;
  logic                  fetch_killed;

  assign busy = (state_q != IDLE);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // next state, transaction capture and completion outputs
  always_comb begin
    done         = busy && (MemAck || expired);
    timeout      = done && !MemAck;
    // a kill on the completing cycle squashes the fetch as well
    fetch_killed = kill_q || IKillF;
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    kill_d       = kill_q;
    bus_err_d    = bus_err_q || timeout;
    IValidF      = 1'b0;
    IRdataF      = '0;
    DValidM      = 1'b0;
    DRdataM      = '0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (DReqM) begin
          state_d     = BUSY_D;
          mem_we_d    = DWriteM;
          mem_addr_d  = DAddrM;
          mem_wdata_d = DWriteDataM;
        end else if (IReqF && !IKillF) begin
          state_d     = BUSY_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = IAddrF;
          mem_wdata_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        if (done) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (!fetch_killed && MemAck) begin
            IValidF = 1'b1;
            IRdataF = MemRData;
          end else if (!fetch_killed) begin
            IValidF = 1'b1;
            IRdataF = '0;
          end else begin
            IValidF = 1'b0;
            IRdataF = '0;
          end
        end else begin
          state_d = BUSY_I;
          kill_d  = kill_q || IKillF;
        end
      end
      BUSY_D: begin
        if (done) begin
          state_d = IDLE;
          DValidM = 1'b1;
          if (MemAck) begin
            DRdataM = MemRData;
          end else begin
            DRdataM = '0;
          end
        end else begin
          state_d = BUSY_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      kill_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      kill_q      <= kill_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign MemReq   = busy;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign BusErr   = bus_err_q;
  assign StallF   = IReqF && !IValidF;
  assign StallM   = DReqM && !DValidM;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench: fetch/data requesters and a latency-randomised memory
// around mem_arbiter, checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReqF, IKillF, IValidF;
  logic [31:0] IAddrF, IRdataF;
  logic        DReqM, DWriteM, DValidM;
  logic [31:0] DAddrM, DWriteDataM, DRdataM;
  logic        StallF, StallM, MemReq, MemWe, MemAck, BusErr;
  logic [31:0] MemAddr, MemWData, MemRData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  // requester and responder state
  logic        f_req, f_done, d_req, d_done, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  int          rsp_age, rsp_lat;

  // reference model
  logic m_active, m_killed, m_err;
  int   m_age;
  txn_t m_t;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .IKillF(IKillF), .IRdataF(IRdataF), .IValidF(IValidF),
    .DReqM(DReqM), .DWriteM(DWriteM), .DAddrM(DAddrM), .DWriteDataM(DWriteDataM),
    .DRdataM(DRdataM), .DValidM(DValidM), .StallF(StallF), .StallM(StallM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at time %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  task automatic drive_cycle(input logic allow_reset);
    int unsigned r;
    reset = allow_reset && ($urandom_range(0, 149) == 0);
    if (f_done) f_req = 1'b0;
    if (!f_req && ($urandom_range(0, 2) == 0)) begin
      f_req  = 1'b1;
      f_addr = rand_addr();
    end
    IReqF  = f_req;
    IAddrF = f_addr;
    IKillF = f_req && ($urandom_range(0, 11) == 0);
    if (d_done) d_req = 1'b0;
    if (!d_req && ($urandom_range(0, 3) == 0)) begin
      d_req   = 1'b1;
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = rand_addr();
      d_wdata = $urandom;
    end
    DReqM       = d_req;
    DWriteM     = d_we;
    DAddrM      = d_addr;
    DWriteDataM = d_wdata;
    // memory: latency 0..3 beyond the first busy cycle, or never (watchdog)
    if (!MemReq) begin
      rsp_age = 0;
    end else if (rsp_age == 0) begin
      r       = $urandom_range(0, 9);
      rsp_lat = (r < 8) ? int'(r % 3) : ((r == 8) ? 3 : 99);
    end
    MemAck   = MemReq ? (rsp_age == rsp_lat) : ($urandom_range(0, 7) == 0);
    MemRData = $urandom;
    if (MemReq && MemAck) begin
      if (MemWe) mem[MemAddr[9:2]] = MemWData;
      else       MemRData = mem[MemAddr[9:2]];
    end
    if (MemReq) rsp_age++;
  endtask

  task automatic check_and_step();
    logic        done, tmo, e_iv, e_dv;
    logic [31:0] e_word;
    done   = m_active && (MemAck || (m_age == TB_TIMEOUT));
    tmo    = done && !MemAck;
    e_iv   = done && !m_t.is_data && !(m_killed || IKillF);
    e_dv   = done && m_t.is_data;
    e_word = tmo ? 32'd0 : ref_mem[m_t.addr[9:2]];
    check_eq("MemReq", 32'(MemReq), 32'(m_active));
    if (m_active) begin
      check_eq("MemAddr", MemAddr, m_t.addr);
      check_eq("MemWe", 32'(MemWe), 32'(m_t.we));
      if (m_t.we) check_eq("MemWData", MemWData, m_t.wdata);
    end
    check_eq("IValidF", 32'(IValidF), 32'(e_iv));
    check_eq("IRdataF", IRdataF, e_iv ? e_word : 32'd0);
    check_eq("DValidM", 32'(DValidM), 32'(e_dv));
    if (!(e_dv && m_t.we)) check_eq("DRdataM", DRdataM, e_dv ? e_word : 32'd0);
    check_eq("StallF", 32'(StallF), 32'(IReqF && !e_iv));
    check_eq("StallM", 32'(StallM), 32'(DReqM && !e_dv));
    check_eq("BusErr", 32'(BusErr), 32'(m_err));
    if (done && MemAck && m_t.we) ref_mem[m_t.addr[9:2]] = m_t.wdata;
    if (reset) begin
      m_active = 1'b0;
      m_err    = 1'b0;
    end else if (m_active) begin
      if (done) begin
        m_active = 1'b0;
        if (tmo) m_err = 1'b1;
      end else begin
        m_age++;
        if (IKillF) m_killed = 1'b1;
      end
    end else if (DReqM) begin
      m_active = 1'b1;
      m_age    = 1;
      m_killed = 1'b0;
      m_t      = '{is_data: 1'b1, we: DWriteM, addr: DAddrM, wdata: DWriteDataM};
    end else if (IReqF && !IKillF) begin
      m_active = 1'b1;
      m_age    = 1;
      m_killed = 1'b0;
      m_t      = '{is_data: 1'b0, we: 1'b0, addr: IAddrF, wdata: 32'd0};
    end
    f_done = IValidF || IKillF;
    d_done = DValidM;
  endtask

  initial begin
    reset = 1'b1;
    IReqF = 1'b0; IAddrF = 32'd0; IKillF = 1'b0;
    DReqM = 1'b0; DWriteM = 1'b0; DAddrM = 32'd0; DWriteDataM = 32'd0;
    MemRData = 32'd0; MemAck = 1'b0;
    f_req = 1'b0; f_done = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_done = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    rsp_age = 0; rsp_lat = 0;
    m_active = 1'b0; m_killed = 1'b0; m_err = 1'b0; m_age = 0; m_t = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_MemReq", 32'(MemReq), 32'd0);
    check_eq("rst_MemWe", 32'(MemWe), 32'd0);
    check_eq("rst_MemAddr", MemAddr, 32'd0);
    check_eq("rst_MemWData", MemWData, 32'd0);
    check_eq("rst_BusErr", 32'(BusErr), 32'd0);
    check_eq("rst_IValidF", 32'(IValidF), 32'd0);
    check_eq("rst_DValidM", 32'(DValidM), 32'd0);
    check_eq("rst_IRdataF", IRdataF, 32'd0);
    check_eq("rst_DRdataM", DRdataM, 32'd0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      drive_cycle(cyc > 0);
      @(negedge clk);
      check_and_step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
